d_sramlike_axi_bridge: RTL and testbench
========================================

// Module: d_sramlike_axi_bridge
// PURPOSE
//  Responder end of the data-side sram-like bus (cache_data_* from the data cache).
//  Converts each accepted sram-like request into one single-beat AXI3 read or write, and returns addr_ok/data_ok/rdata.
//  Sits between the data cache and the top-level AXI master port.
//  One transaction is outstanding at a time.
// PARAMETERS
//  AXI_ID     4'd1  value driven on arid/awid
//  ADDR_W     32    address width (sram-like and AXI)
//  DATA_W     32    data width; wstrb is DATA_W/8 bits
// PORTS
//  clk                   in   1   single clock, all logic on posedge
//  rst                   in   1   synchronous, active-high reset
//  data_req              in   1   request valid from cache
//  data_wr               in   1   1=write, 0=read
//  data_size             in   2   00 byte, 01 half, 10 word
//  data_addr             in   32  byte address
//  data_wdata            in   32  write data, byte lanes per addr[1:0]
//  data_addr_ok          out  1   request accepted this cycle
//  data_data_ok          out  1   one-cycle pulse: read data valid / write done
//  data_rdata            out  32  read data, valid only while data_data_ok=1
//  arid/awid             out  4   = AXI_ID
//  araddr/awaddr         out  32  latched data_addr
//  arlen/awlen           out  8   = 0 (single beat)
//  arsize/awsize         out  3   = {1'b0, latched data_size}
//  arburst/awburst       out  2   = 2'b01 INCR; arlock/awlock=0, cache=0, prot=0
//  arvalid/arready       out/in 1 read-address handshake
//  rdata/rresp/rlast     in   32/2/1  read data channel
//  rvalid/rready         in/out 1 read-data handshake
//  awvalid/awready       out/in 1 write-address handshake
//  wdata/wstrb/wlast     out  32/4/1  latched wdata, strobe, wlast=1
//  wvalid/wready         out/in 1 write-data handshake
//  bresp                 in   2   write response (ignored)
//  bvalid/bready         in/out 1 write-response handshake
// BEHAVIOUR
//  Reset: state=IDLE; arvalid, awvalid, wvalid, rready, bready, data_data_ok = 0.
//   Latched addr/size/wdata/wstrb = 0.
//  data_addr_ok = data_req & (state==IDLE). This is combinational, so addr_ok can be seen in the same cycle as req.
//   On a handshake, latch wr/size/addr/wdata and compute wstrb.
//  wstrb: size 00 -> 4'b0001<<addr[1:0]; size 01 -> addr[1] ? 1100 : 0011; size 10 -> 1111. Size 11 is treated as 10.
//  FSM IDLE -> RADDR | WADDR on handshake (by wr).
//   RADDR: arvalid=1 until arready, then -> RDATA.
//   RDATA: rready=1. On rvalid: data_data_ok=1, data_rdata=rdata (combinational passthrough), then -> IDLE.
//   WADDR: awvalid and wvalid are both raised on entry.
//    Each drops independently on its own ready (flags aw_done/w_done).
//    When both are done (same or different cycles) -> WRESP.
//   WRESP: bready=1. On bvalid: data_data_ok=1, then -> IDLE.
//  Latency with zero-wait AXI:
//   read: req/addr_ok at T0, arvalid T1, rvalid T2 earliest, data_ok same cycle as rvalid.
//   write: data_ok same cycle as bvalid.
//  No new addr_ok during the data_ok cycle; the next acceptance is at data_ok+1 at the earliest.
//  rresp/bresp errors are ignored; data_data_ok still pulses exactly once.
//  AXI valids are never withdrawn before ready.
//   Latched fields are held stable while valid=1 even if data_req/data_addr change.
//  rvalid/bvalid seen outside RDATA/WRESP are ignored (ready=0).
//  rst mid-transaction: the next cycle is IDLE and all valids are low; the outstanding AXI transaction is abandoned.
//   Reset is asserted only with the AXI slave quiescent.
// STRUCTURE
//  Shared package: FSM state encoding (IDLE, RADDR, RDATA, WADDR, WRESP); AXI constants (BURST_INCR, size codes); sram-like size codes.
//  Sub-module sramlike_wstrb (size, addr[1:0] -> 4-bit strobe). It is combinational and reused by the instruction-side bridge.
// TESTING
//  1 Read word: req wr=0 addr=0x1000_0004 size=10; arready=1 T1, rvalid T3 rdata=0xDEADBEEF
//    -> addr_ok T0, araddr=0x1000_0004 arsize=010, data_ok only at T3, data_rdata=0xDEADBEEF.
//  2 Write byte: addr=0x...0003 size=00 wdata=0xAA000000
//    -> wstrb=1000, awsize=000, wlast=1; data_ok the cycle bvalid arrives.
//  3 Split write handshake: awready at T2, wready at T5
//    -> awvalid drops after T2, wvalid held until T5, bready from T6, single data_ok.
//  4 Back-to-back: req held high across a read completion
//    -> second addr_ok exactly one cycle after first data_ok; no overlap of arvalid.
//  5 Backpressure: arready low 10 cycles while data_addr changes
//    -> araddr and arvalid stable throughout; no addr_ok for the second request.
//  6 rst asserted in RDATA
//    -> next cycle all valids/readies 0, state IDLE; a later read completes normally.

Source files
------------

// File: rtl/d_sramlike_axi_bridge_pkg.sv
// Shared types and constants for the sram-like to AXI3 bridges.
package d_sramlike_axi_bridge_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RADDR = 3'd1,
    ST_RDATA = 3'd2,
    ST_WADDR = 3'd3,
    ST_WRESP = 3'd4
  } state_t;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [7:0] AXI_LEN_SINGLE = 8'd0;

  localparam logic [1:0] SRAM_SIZE_BYTE = 2'b00;
  localparam logic [1:0] SRAM_SIZE_HALF = 2'b01;
  localparam logic [1:0] SRAM_SIZE_WORD = 2'b10;

endpackage

// File: rtl/d_sramlike_axi_bridge_wstrb.sv
// Byte-lane strobe from sram-like size and low address bits; shared with the
// instruction-side bridge.
module sramlike_wstrb
  import d_sramlike_axi_bridge_pkg::*;
(
  input  logic [1:0] size,
  input  logic [1:0] addr_lo,
  output logic [3:0] wstrb
);

  always_comb begin
    wstrb = 4'b1111;
    case (size)
      SRAM_SIZE_BYTE: wstrb = 4'b0001 << addr_lo;
      SRAM_SIZE_HALF: wstrb = addr_lo[1] ? 4'b1100 : 4'b0011;
      // the reserved size code behaves like a full word
      default:        wstrb = 4'b1111;
    endcase
  end

endmodule

// File: rtl/d_sramlike_axi_bridge.sv
// Data-side sram-like responder: each accepted request becomes one single-beat
// AXI3 read or write, one transaction outstanding at a time.
//
// state    | meaning
// IDLE     | ready to accept a request (addr_ok follows data_req)
// RADDR    | arvalid held until arready
// RDATA    | rready held; rvalid ends the read with data_ok
// WADDR    | awvalid/wvalid each held until their own ready
// WRESP    | bready held; bvalid ends the write with data_ok
module d_sramlike_axi_bridge
  import d_sramlike_axi_bridge_pkg::*;
#(
  parameter logic [3:0] AXI_ID = 4'd1,
  parameter int         ADDR_W = 32,
  parameter int         DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  data_req,
  input  logic                  data_wr,
  input  logic [1:0]            data_size,
  input  logic [ADDR_W-1:0]     data_addr,
  input  logic [DATA_W-1:0]     data_wdata,
  output logic                  data_addr_ok,
  output logic                  data_data_ok,
  output logic [DATA_W-1:0]     data_rdata,
  output logic [3:0]            arid,
  output logic [ADDR_W-1:0]     araddr,
  output logic [7:0]            arlen,
  output logic [2:0]            arsize,
  output logic [1:0]            arburst,
  output logic [1:0]            arlock,
  output logic [3:0]            arcache,
  output logic [2:0]            arprot,
  output logic                  arvalid,
  input  logic                  arready,
  input  logic [3:0]            rid,
  input  logic [DATA_W-1:0]     rdata,
  input  logic [1:0]            rresp,
  input  logic                  rlast,
  input  logic                  rvalid,
  output logic                  rready,
  output logic [3:0]            awid,
  output logic [ADDR_W-1:0]     awaddr,
  output logic [7:0]            awlen,
  output logic [2:0]            awsize,
  output logic [1:0]            awburst,
  output logic [1:0]            awlock,
  output logic [3:0]            awcache,
  output logic [2:0]            awprot,
  output logic                  awvalid,
  input  logic                  awready,
  output logic [3:0]            wid,
  output logic [DATA_W-1:0]     wdata,
  output logic [DATA_W/8-1:0]   wstrb,
  output logic                  wlast,
  output logic                  wvalid,
  input  logic                  wready,
  input  logic [3:0]            bid,
  input  logic [1:0]            bresp,
  input  logic                  bvalid,
  output logic                  bready
);

  state_t              state_q, state_d;
  logic [1:0]          size_q, size_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W/8-1:0] wstrb_q, wstrb_d;
  logic                aw_done_q, aw_done_d;
  logic                w_done_q, w_done_d;
  logic [3:0]          req_wstrb;
  logic                accept;

  // responses are not checked: error responses still complete the request
  logic unused_inputs;
  assign unused_inputs = ^{rid, rresp, rlast, bid, bresp};

  sramlike_wstrb u_wstrb (
    .size    (data_size),
    .addr_lo (data_addr[1:0]),
    .wstrb   (req_wstrb)
  );

  assign accept = data_req && (state_q == ST_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      size_q    <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      size_q    <= size_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  always_comb begin
    size_d    = size_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    if (accept) begin
      size_d    = data_size;
      addr_d    = data_addr;
      wdata_d   = data_wdata;
      wstrb_d   = req_wstrb;
      aw_done_d = 1'b0;
      w_done_d  = 1'b0;
    end else if (state_q == ST_WADDR) begin
      aw_done_d = aw_done_q | awready;
      w_done_d  = w_done_q | wready;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (data_req) state_d = data_wr ? ST_WADDR : ST_RADDR;
      ST_RADDR: if (arready) state_d = ST_RDATA;
      ST_RDATA: if (rvalid) state_d = ST_IDLE;
      ST_WADDR: if (aw_done_d && w_done_d) state_d = ST_WRESP;
      ST_WRESP: if (bvalid) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    data_addr_ok = accept;
    data_data_ok = ((state_q == ST_RDATA) && rvalid) || ((state_q == ST_WRESP) && bvalid);
    data_rdata   = rdata;
    arvalid      = (state_q == ST_RADDR);
    rready       = (state_q == ST_RDATA);
    awvalid      = (state_q == ST_WADDR) && !aw_done_q;
    wvalid       = (state_q == ST_WADDR) && !w_done_q;
    bready       = (state_q == ST_WRESP);
  end

  assign arid    = AXI_ID;
  assign araddr  = addr_q;
  assign arlen   = AXI_LEN_SINGLE;
  assign arsize  = {1'b0, size_q};
  assign arburst = AXI_BURST_INCR;
  assign arlock  = 2'b00;
  assign arcache = 4'b0000;
  assign arprot  = 3'b000;

  assign awid    = AXI_ID;
  assign awaddr  = addr_q;
  assign awlen   = AXI_LEN_SINGLE;
  assign awsize  = {1'b0, size_q};
  assign awburst = AXI_BURST_INCR;
  assign awlock  = 2'b00;
  assign awcache = 4'b0000;
  assign awprot  = 3'b000;

  assign wid     = AXI_ID;
  assign wdata   = wdata_q;
  assign wstrb   = wstrb_q;
  assign wlast   = 1'b1;

endmodule

// File: tb/tb_d_sramlike_axi_bridge.sv
// Directed bench for the data-side sram-like to AXI3 bridge.
module tb_d_sramlike_axi_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        data_req = 1'b0, data_wr = 1'b0;
  logic [1:0]  data_size = 2'b00;
  logic [31:0] data_addr = '0, data_wdata = '0;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic [3:0]  arid, awid, wid, arcache, awcache;
  logic [31:0] araddr, awaddr, wdata;
  logic [7:0]  arlen, awlen;
  logic [2:0]  arsize, awsize, arprot, awprot;
  logic [1:0]  arburst, awburst, arlock, awlock;
  logic        arvalid, awvalid, wvalid, rready, bready, wlast;
  logic [3:0]  wstrb;
  logic        arready = 1'b0, rvalid = 1'b0, awready = 1'b0, wready = 1'b0, bvalid = 1'b0;
  logic [31:0] rdata = '0;
  logic [1:0]  rresp = 2'b00, bresp = 2'b00;
  logic        rlast = 1'b1;
  logic [3:0]  rid = 4'd1, bid = 4'd1;

  int n_vec = 0;
  int n_err = 0;

  d_sramlike_axi_bridge dut (
    .clk(clk), .rst(rst),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // inputs change 1 time unit after the rising edge, checks 1 unit later
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic slv(input logic ar, input logic rv, input logic aw, input logic w, input logic bv);
    arready = ar; rvalid = rv; awready = aw; wready = w; bvalid = bv;
  endtask

  task automatic req(input logic r, input logic wr, input logic [1:0] sz,
                     input logic [31:0] a, input logic [31:0] wd);
    data_req = r; data_wr = wr; data_size = sz; data_addr = a; data_wdata = wd;
  endtask

  initial begin
    // reset
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("rst_arvalid", arvalid, 0);
    chk("rst_awvalid", awvalid, 0);
    chk("rst_wvalid", wvalid, 0);
    chk("rst_rready", rready, 0);
    chk("rst_bready", bready, 0);
    chk("rst_data_ok", data_data_ok, 0);
    chk("rst_araddr", araddr, 0);
    chk("rst_wstrb", wstrb, 0);

    // 1: read word, arready at T1, rvalid at T3
    tick(); req(1, 0, 2'b10, 32'h1000_0004, 0); #1;
    chk("t1_addr_ok_T0", data_addr_ok, 1);
    chk("t1_data_ok_T0", data_data_ok, 0);
    tick(); req(0, 0, 0, 32'hFFFF_FFF0, 0); slv(1, 0, 0, 0, 0); #1;
    chk("t1_arvalid_T1", arvalid, 1);
    chk("t1_araddr", araddr, 32'h1000_0004);
    chk("t1_arsize", arsize, 3'b010);
    chk("t1_arlen", arlen, 0);
    chk("t1_arburst", arburst, 2'b01);
    chk("t1_arid", arid, 4'd1);
    chk("t1_data_ok_T1", data_data_ok, 0);
    tick(); slv(0, 0, 0, 0, 0); #1;
    chk("t1_arvalid_T2", arvalid, 0);
    chk("t1_rready_T2", rready, 1);
    chk("t1_data_ok_T2", data_data_ok, 0);
    tick(); slv(0, 1, 0, 0, 0); rdata = 32'hDEAD_BEEF; #1;
    chk("t1_data_ok_T3", data_data_ok, 1);
    chk("t1_rdata", data_rdata, 32'hDEAD_BEEF);
    tick(); slv(0, 0, 0, 0, 0); #1;
    chk("t1_data_ok_T4", data_data_ok, 0);
    chk("t1_rready_T4", rready, 0);

    // 2: write byte at lane 3, both readies at once, error bresp
    tick(); req(1, 1, 2'b00, 32'h2000_0003, 32'hAA00_0000); #1;
    chk("t2_addr_ok", data_addr_ok, 1);
    tick(); req(0, 0, 0, 0, 0); slv(0, 0, 1, 1, 0); #1;
    chk("t2_awvalid", awvalid, 1);
    chk("t2_wvalid", wvalid, 1);
    chk("t2_wstrb", wstrb, 4'b1000);
    chk("t2_awsize", awsize, 3'b000);
    chk("t2_wlast", wlast, 1);
    chk("t2_wdata", wdata, 32'hAA00_0000);
    chk("t2_awaddr", awaddr, 32'h2000_0003);
    tick(); slv(0, 0, 0, 0, 0); #1;
    chk("t2_bready", bready, 1);
    chk("t2_awvalid_done", awvalid, 0);
    chk("t2_data_ok_early", data_data_ok, 0);
    tick(); slv(0, 0, 0, 0, 1); bresp = 2'b10; #1;
    chk("t2_data_ok", data_data_ok, 1);
    tick(); slv(0, 0, 0, 0, 0); bresp = 2'b00; #1;
    chk("t2_data_ok_after", data_data_ok, 0);

    // 2b: upper half-word strobe
    tick(); req(1, 1, 2'b01, 32'h2000_0006, 32'h5566_0000); #1;
    tick(); req(0, 0, 0, 0, 0); slv(0, 0, 1, 1, 0); #1;
    chk("t2b_wstrb", wstrb, 4'b1100);
    chk("t2b_awsize", awsize, 3'b001);
    tick(); slv(0, 0, 0, 0, 1); #1;
    chk("t2b_data_ok", data_data_ok, 1);
    tick(); slv(0, 0, 0, 0, 0); #1;

    // 3: split write handshake, awready at T2, wready at T5
    tick(); req(1, 1, 2'b10, 32'h3000_0008, 32'h1234_5678); #1;
    chk("t3_addr_ok", data_addr_ok, 1);
    tick(); req(0, 0, 0, 0, 0); #1;
    chk("t3_wstrb", wstrb, 4'b1111);
    chk("t3_awvalid_T1", awvalid, 1);
    tick(); slv(0, 0, 1, 0, 0); #1;
    chk("t3_awvalid_T2", awvalid, 1);
    chk("t3_wvalid_T2", wvalid, 1);
    for (int t = 3; t <= 4; t++) begin
      tick(); slv(0, 0, 0, 0, 0); #1;
      chk($sformatf("t3_awvalid_T%0d", t), awvalid, 0);
      chk($sformatf("t3_wvalid_T%0d", t), wvalid, 1);
      chk($sformatf("t3_bready_T%0d", t), bready, 0);
    end
    tick(); slv(0, 0, 0, 1, 0); #1;
    chk("t3_wvalid_T5", wvalid, 1);
    chk("t3_bready_T5", bready, 0);
    tick(); slv(0, 0, 0, 0, 0); #1;
    chk("t3_bready_T6", bready, 1);
    chk("t3_wvalid_T6", wvalid, 0);
    chk("t3_data_ok_T6", data_data_ok, 0);
    tick(); slv(0, 0, 0, 0, 1); #1;
    chk("t3_data_ok_T7", data_data_ok, 1);
    tick(); slv(0, 0, 0, 0, 0); #1;
    chk("t3_data_ok_T8", data_data_ok, 0);

    // 4: back-to-back reads with req held high
    tick(); req(1, 0, 2'b10, 32'h4000_0000, 0); #1;
    chk("t4_addr_ok_1", data_addr_ok, 1);
    tick(); req(1, 0, 2'b10, 32'h4000_0010, 0); slv(1, 0, 0, 0, 0); #1;
    chk("t4_addr_ok_busy", data_addr_ok, 0);
    chk("t4_araddr_1", araddr, 32'h4000_0000);
    tick(); slv(0, 1, 0, 0, 0); rdata = 32'h0000_0011; #1;
    chk("t4_data_ok_1", data_data_ok, 1);
    chk("t4_addr_ok_in_data_ok", data_addr_ok, 0);
    chk("t4_arvalid_in_data_ok", arvalid, 0);
    tick(); slv(0, 0, 0, 0, 0); #1;
    chk("t4_addr_ok_2", data_addr_ok, 1);
    chk("t4_arvalid_gap", arvalid, 0);
    tick(); req(0, 0, 0, 0, 0); slv(1, 0, 0, 0, 0); #1;
    chk("t4_arvalid_2", arvalid, 1);
    chk("t4_araddr_2", araddr, 32'h4000_0010);
    tick(); slv(0, 1, 0, 0, 0); rdata = 32'h0000_0022; #1;
    chk("t4_data_ok_2", data_data_ok, 1);
    chk("t4_rdata_2", data_rdata, 32'h0000_0022);
    tick(); slv(0, 0, 0, 0, 0); #1;

    // 5: arready held low 10 cycles while the cache changes its request
    tick(); req(1, 0, 2'b01, 32'h5000_0002, 0); #1;
    chk("t5_addr_ok", data_addr_ok, 1);
    for (int i = 0; i < 10; i++) begin
      tick(); req(1, (i % 2) == 1, 2'b10, 32'h6000_0000 + 32'(i * 4), 32'hFFFF_0000 + 32'(i)); #1;
      chk($sformatf("t5_arvalid_%0d", i), arvalid, 1);
      chk($sformatf("t5_araddr_%0d", i), araddr, 32'h5000_0002);
      chk($sformatf("t5_arsize_%0d", i), arsize, 3'b001);
      chk($sformatf("t5_addr_ok_%0d", i), data_addr_ok, 0);
      chk($sformatf("t5_awvalid_%0d", i), awvalid, 0);
    end
    tick(); req(0, 0, 0, 0, 0); slv(1, 0, 0, 0, 0); #1;
    chk("t5_arvalid_last", arvalid, 1);
    tick(); slv(0, 1, 0, 0, 0); rdata = 32'hBEEF_0000; #1;
    chk("t5_data_ok", data_data_ok, 1);
    chk("t5_rdata", data_rdata, 32'hBEEF_0000);
    tick(); slv(0, 0, 0, 0, 0); #1;

    // 6: reset while in RDATA, then a clean read
    tick(); req(1, 0, 2'b10, 32'h7000_0000, 0); #1;
    chk("t6_addr_ok", data_addr_ok, 1);
    tick(); req(0, 0, 0, 0, 0); slv(1, 0, 0, 0, 0); #1;
    tick(); slv(0, 0, 0, 0, 0); rst = 1'b1; #1;
    chk("t6_rready_before_rst", rready, 1);
    tick(); rst = 1'b0; req(1, 0, 2'b10, 32'h7000_0010, 0); #1;
    chk("t6_rready", rready, 0);
    chk("t6_arvalid", arvalid, 0);
    chk("t6_awvalid", awvalid, 0);
    chk("t6_wvalid", wvalid, 0);
    chk("t6_bready", bready, 0);
    chk("t6_data_ok", data_data_ok, 0);
    chk("t6_idle_addr_ok", data_addr_ok, 1);
    tick(); req(0, 0, 0, 0, 0); slv(1, 0, 0, 0, 0); #1;
    chk("t6_arvalid_2", arvalid, 1);
    chk("t6_araddr_2", araddr, 32'h7000_0010);
    tick(); slv(0, 1, 0, 0, 0); rdata = 32'hCAFE_F00D; #1;
    chk("t6_data_ok_2", data_data_ok, 1);
    chk("t6_rdata_2", data_rdata, 32'hCAFE_F00D);
    tick(); slv(0, 0, 0, 0, 0); #1;
    chk("t6_data_ok_end", data_data_ok, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
